vga_timing_gen: RTL and testbench

//  Raster timing master for the 640x480@60 Hz VGA display path. Divides clk into a pixel-rate enable,

---
 rtl/vga_timing_pkg.sv | 58 +++++
 rtl/vga_pix_en_gen.sv | 42 ++++
 rtl/vga_timing_gen.sv | 153 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the 640x480@60 Hz raster timing generator: default
// porch/sync geometry, derived totals and sync windows, and the colour-bar
// table used by the optional test pattern.
package vga_timing_pkg;

  localparam int CLK_DIV_DEF = 4;

  localparam int H_VIS_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int H_TOTAL_DEF = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_VIS_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;
  localparam int V_TOTAL_DEF = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int H_SYNC_START_DEF = H_VIS_DEF + H_FP_DEF;
  localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
  localparam int V_SYNC_START_DEF = V_VIS_DEF + V_FP_DEF;
  localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

  // Bars left to right across the visible width
  typedef enum logic [2:0] {
    BAR_WHITE   = 3'd0,
    BAR_YELLOW  = 3'd1,
    BAR_CYAN    = 3'd2,
    BAR_GREEN   = 3'd3,
    BAR_MAGENTA = 3'd4,
    BAR_RED     = 3'd5,
    BAR_BLUE    = 3'd6,
    BAR_BLACK   = 3'd7
  } bar_e;

  localparam logic [11:0] RGB_WHITE = 12'hFFF;
  localparam logic [11:0] RGB_BLACK = 12'h000;

  // 4:4:4 {R,G,B} colour for each bar index
  function automatic logic [11:0] bar_colour(input bar_e bar);
    logic [11:0] rgb;
    rgb = RGB_BLACK;
    case (bar)
      BAR_WHITE:   rgb = 12'hFFF;
      BAR_YELLOW:  rgb = 12'hFF0;
      BAR_CYAN:    rgb = 12'h0FF;
      BAR_GREEN:   rgb = 12'h0F0;
      BAR_MAGENTA: rgb = 12'hF0F;
      BAR_RED:     rgb = 12'hF00;
      BAR_BLUE:    rgb = 12'h00F;
      BAR_BLACK:   rgb = 12'h000;
      default:     rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_pix_en_gen.sv
// Pixel-rate strobe generator: divides the system clock by CLK_DIV.
// tick_o marks the clock edge on which the raster advances; pix_en_o is the
// registered copy of it, high for the one clock that follows that edge.
module vga_pix_en_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic tick_o,
  output logic pix_en_o
);

  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic       pix_en_q;

  assign tick_o   = (div_cnt_q == DIV_MAX);
  assign pix_en_o = pix_en_q;

  // Free-running divider that wraps after CLK_DIV-1
  always_comb begin
    div_cnt_d = div_cnt_q + 4'd1;
    if (tick_o) begin
      div_cnt_d = 4'd0;
    end
  end

  // Divider state and the registered pixel strobe
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_cnt_q <= 4'd0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= tick_o;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing master for the VGA path: horizontal/vertical counters,
// active-low syncs, video_on and line/frame start pulses, all registered
// from the next-state position so nothing skews against the counters.
// Optional feature: define VGA_TEST_PATTERN_EN to build the colour-bar
// test pattern on pat_rgb; otherwise pat_rgb is tied to zero.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int H_VIS   = H_VIS_DEF,
  parameter int H_FP    = H_FP_DEF,
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BP    = H_BP_DEF,
  parameter int V_VIS   = V_VIS_DEF,
  parameter int V_FP    = V_FP_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BP    = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_en,
  output logic [9:0]  x_counter,
  output logic [9:0]  y_counter,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic        line_start,
  output logic [11:0] pat_rgb
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  // Counters are 10 bits wide and the divider 4 bits wide
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL-1 does not fit in 10 bits");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL-1 does not fit in 10 bits");
  end
  if (CLK_DIV < 2 || CLK_DIV > 15) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be in 2..15");
  end

  logic       tick;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, vsync_q, video_on_q, frame_start_q, line_start_q;
  logic       video_on_d;

  vga_pix_en_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_en_gen (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .tick_o   (tick),
    .pix_en_o (pix_en)
  );

  // Next raster position: advance x on a tick, carry into y on line wrap
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      if (x_q == H_MAX) begin
        x_d = 10'd0;
        y_d = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  assign video_on_d = (x_d < H_VIS_W) && (y_d < V_VIS_W);

  // Counters and decoded outputs; reset parks at the last pixel so the first tick lands on (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q           <= H_MAX;
      y_q           <= V_MAX;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      if (tick) begin
        x_q           <= x_d;
        y_q           <= y_d;
        hsync_q       <= !((x_d >= HS_START) && (x_d < HS_END));
        vsync_q       <= !((y_d >= VS_START) && (y_d < VS_END));
        video_on_q    <= video_on_d;
        line_start_q  <= (x_d == 10'd0);
        frame_start_q <= (x_d == 10'd0) && (y_d == 10'd0);
      end
    end
  end

  assign x_counter   = x_q;
  assign y_counter   = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;

`ifdef VGA_TEST_PATTERN_EN
  // Each bar spans one eighth of the visible width (80 px at 640)
  localparam logic [9:0] BAR_W = 10'(H_VIS / 8);

  logic [11:0] pat_q, pat_d;
  logic [2:0]  bar_idx;

  // Colour bars framed by a 1-px white border, black outside the visible area
  always_comb begin
    bar_idx = 3'(x_d / BAR_W);
    pat_d   = RGB_BLACK;
    if (video_on_d) begin
      if ((x_d == 10'd0) || (x_d == H_VIS_W - 10'd1) ||
          (y_d == 10'd0) || (y_d == V_VIS_W - 10'd1)) begin
        pat_d = RGB_WHITE;
      end else begin
        pat_d = bar_colour(bar_e'(bar_idx));
      end
    end
  end

  // Pattern register advances with the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= 12'h000;
    end else if (tick) begin
      pat_q <= pat_d;
    end
  end

  assign pat_rgb = pat_q;
`else
  assign pat_rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen. A full 640x480 instance checks the
// reset values, first tick, one complete line and the pattern on line 1; a
// reduced-geometry instance (80x32 totals) makes full-frame and mid-frame
// reset scenarios affordable. Both share clock and reset, so ticks align.
// Reduced geometry: H 64/4/8/4 (hsync low x=68..75), V 24/3/2/3 (vsync low y=27..28).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s_pix_en, s_hs, s_vs, s_vo, s_fs, s_ls;
  logic [9:0]  s_x, s_y;
  logic [11:0] s_pat;

  logic        f_pix_en, f_hs, f_vs, f_vo, f_fs, f_ls;
  logic [9:0]  f_x, f_y;
  logic [11:0] f_pat;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen #(
    .CLK_DIV(4), .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(24), .V_FP(3), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(s_pix_en), .x_counter(s_x), .y_counter(s_y),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_vo), .frame_start(s_fs),
    .line_start(s_ls), .pat_rgb(s_pat)
  );

  vga_timing_gen dut_full (
    .clk(clk), .rst_n(rst_n), .pix_en(f_pix_en), .x_counter(f_x), .y_counter(f_y),
    .hsync(f_hs), .vsync(f_vs), .video_on(f_vo), .frame_start(f_fs),
    .line_start(f_ls), .pat_rgb(f_pat)
  );

  // Advance to the next sample where pix_en is high; a missing strobe is a failure
  task automatic next_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (s_pix_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++; fails++;
      $display("[TB] FAIL tick_timeout: pix_en not seen within 16 clk");
    end
  endtask

  // Release reset on a falling edge and count edges until pix_en is seen.
  // pix_en is set by edge 4, so it is already high when edge 5 arrives.
  task automatic release_and_check_first_tick(input string tag);
    int edges;
    edges = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      edges++;
      if (s_pix_en) break;
    end
    tests++;
    if (edges !== 4) begin fails++; $display("[TB] FAIL %s_first_pix_en: got %0d edges, want 4", tag, edges); end
    tests++;
    if ({s_x, s_y} !== {10'd0, 10'd0}) begin fails++; $display("[TB] FAIL %s_first_xy: got (%0d,%0d), want (0,0)", tag, s_x, s_y); end
    tests++;
    if ({s_fs, s_ls, s_vo, s_hs, s_vs} !== 5'b11111) begin
      fails++; $display("[TB] FAIL %s_first_flags: fs/ls/vo/hs/vs got %b, want 11111", tag, {s_fs, s_ls, s_vo, s_hs, s_vs});
    end
    tests++;
    if ({f_x, f_y, f_fs, f_ls, f_vo, f_hs, f_vs} !== {10'd0, 10'd0, 5'b11111}) begin
      fails++; $display("[TB] FAIL %s_full_first: got (%0d,%0d) flags %b, want (0,0) 11111", tag, f_x, f_y, {f_fs, f_ls, f_vo, f_hs, f_vs});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if ({s_x, s_y} !== {10'd79, 10'd31}) begin fails++; $display("[TB] FAIL reset_xy: got (%0d,%0d), want (79,31)", s_x, s_y); end
    tests++;
    if ({f_x, f_y} !== {10'd799, 10'd524}) begin fails++; $display("[TB] FAIL reset_full_xy: got (%0d,%0d), want (799,524)", f_x, f_y); end
    tests++;
    if ({s_pix_en, s_hs, s_vs, s_vo, s_fs, s_ls, s_pat} !== {6'b011000, 12'h000}) begin
      fails++; $display("[TB] FAIL reset_flags: pe/hs/vs/vo/fs/ls got %b pat %h, want 011000 pat 000", {s_pix_en, s_hs, s_vs, s_vo, s_fs, s_ls}, s_pat);
    end
    release_and_check_first_tick("reset");
  endtask

  // One full 640-wide line on the full-size instance, then pattern points on line 1
  task automatic test_line();
    bit ok;
    int start_cyc, hs_low, hs_first, hs_last, vo_bad;
    logic [11:0] exp_pat;
    start_cyc = cyc; hs_low = 0; hs_first = -1; hs_last = -1; vo_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (!f_hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(f_x);
        hs_last = int'(f_x);
      end
      if (f_vo !== (f_x < 10'd640)) vo_bad++;
      next_tick(ok);
      if (!ok) return;
    end
    tests++;
    if (hs_low !== 96) begin fails++; $display("[TB] FAIL line_hsync_width: got %0d ticks, want 96", hs_low); end
    tests++;
    if (hs_first !== 656 || hs_last !== 751) begin fails++; $display("[TB] FAIL line_hsync_window: got %0d..%0d, want 656..751", hs_first, hs_last); end
    tests++;
    if (vo_bad !== 0) begin fails++; $display("[TB] FAIL line_video_on: got %0d bad ticks, want 0", vo_bad); end
    tests++;
    if ((cyc - start_cyc) !== 3200) begin fails++; $display("[TB] FAIL line_period: got %0d clk, want 3200", cyc - start_cyc); end
    tests++;
    if ({f_x, f_y, f_ls, f_fs} !== {10'd0, 10'd1, 2'b10}) begin
      fails++; $display("[TB] FAIL line_wrap: got (%0d,%0d) ls=%b fs=%b, want (0,1) ls=1 fs=0", f_x, f_y, f_ls, f_fs);
    end
`ifdef VGA_TEST_PATTERN_EN
    exp_pat = 12'hFFF;
`else
    exp_pat = 12'h000;
`endif
    tests++;
    if (f_pat !== exp_pat) begin fails++; $display("[TB] FAIL pat_0_1: got %h, want %h", f_pat, exp_pat); end
    for (int i = 0; i < 100; i++) begin next_tick(ok); if (!ok) return; end
`ifdef VGA_TEST_PATTERN_EN
    exp_pat = 12'hFF0;
`else
    exp_pat = 12'h000;
`endif
    tests++;
    if (f_x !== 10'd100 || f_pat !== exp_pat) begin fails++; $display("[TB] FAIL pat_100_1: got x=%0d pat %h, want x=100 pat %h", f_x, f_pat, exp_pat); end
    for (int i = 0; i < 600; i++) begin next_tick(ok); if (!ok) return; end
    tests++;
    if (f_x !== 10'd700 || f_pat !== 12'h000) begin fails++; $display("[TB] FAIL pat_700_1: got x=%0d pat %h, want x=700 pat 000", f_x, f_pat); end
  endtask

  // One complete frame on the reduced instance
  task automatic test_frame();
    bit ok;
    int start_cyc, vs_low, vs_min, vs_max, hs_low, vs_bad, fs_extra, hits;
    logic prev_vs;
    logic [9:0] last_x, last_y;
    int px[13];
    int py[13];
    logic [11:0] pc[13];
    px = '{0, 9, 17, 25, 33, 41, 49, 57, 63, 9, 9, 70, 9};
    py = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 0, 23, 5, 25};
`ifdef VGA_TEST_PATTERN_EN
    pc = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000,
           12'hFFF, 12'hFFF, 12'hFFF, 12'h000, 12'h000};
`else
    pc = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
           12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
`endif
    ok = 1'b1;
    for (int i = 0; i < 2600 && !s_fs; i++) begin next_tick(ok); if (!ok) return; end
    tests++;
    if (s_fs !== 1'b1) begin fails++; $display("[TB] FAIL frame_sync: got fs=%b, want 1", s_fs); return; end
    start_cyc = cyc; vs_low = 0; vs_min = 1023; vs_max = -1; hs_low = 0; vs_bad = 0; fs_extra = 0; hits = 0;
    prev_vs = s_vs; last_x = '0; last_y = '0;
    for (int i = 0; i < 2560; i++) begin
      if (!s_vs) begin
        vs_low++;
        if (int'(s_y) < vs_min) vs_min = int'(s_y);
        if (int'(s_y) > vs_max) vs_max = int'(s_y);
      end
      if (!s_hs) hs_low++;
      if (i > 0 && s_vs !== prev_vs && s_x !== 10'd0) vs_bad++;
      if (i > 0 && s_fs) fs_extra++;
      for (int k = 0; k < 13; k++) begin
        if (int'(s_x) == px[k] && int'(s_y) == py[k]) begin
          hits++;
          tests++;
          if (s_pat !== pc[k]) begin fails++; $display("[TB] FAIL pat_%0d_%0d: got %h, want %h", px[k], py[k], s_pat, pc[k]); end
        end
      end
      prev_vs = s_vs; last_x = s_x; last_y = s_y;
      next_tick(ok);
      if (!ok) return;
    end
    tests++;
    if (hits !== 13) begin fails++; $display("[TB] FAIL pat_points: got %0d visited, want 13", hits); end
    tests++;
    if (vs_low !== 160 || vs_min !== 27 || vs_max !== 28) begin
      fails++; $display("[TB] FAIL frame_vsync: got %0d ticks y=%0d..%0d, want 160 ticks y=27..28", vs_low, vs_min, vs_max);
    end
    tests++;
    if (hs_low !== 256) begin fails++; $display("[TB] FAIL frame_hsync_total: got %0d, want 256", hs_low); end
    tests++;
    if (vs_bad !== 0) begin fails++; $display("[TB] FAIL frame_vsync_align: got %0d changes off x=0, want 0", vs_bad); end
    tests++;
    if ({last_x, last_y} !== {10'd79, 10'd31} || {s_x, s_y, s_fs} !== {10'd0, 10'd0, 1'b1}) begin
      fails++; $display("[TB] FAIL frame_wrap: got (%0d,%0d)->(%0d,%0d) fs=%b, want (79,31)->(0,0) fs=1", last_x, last_y, s_x, s_y, s_fs);
    end
    tests++;
    if (fs_extra !== 0 || (cyc - start_cyc) !== 10240) begin
      fails++; $display("[TB] FAIL frame_period: got %0d clk, %0d extra pulses, want 10240 clk, 0 extra", cyc - start_cyc, fs_extra);
    end
  endtask

  // Strobe spacing and output stability between ticks
  task automatic test_pix_en();
    bit ok;
    int dbl, unstable, badgap, gap;
    logic prev_pe;
    logic [54:0] snap, prev_snap;
    next_tick(ok);
    if (!ok) return;
    dbl = 0; unstable = 0; badgap = 0; gap = 0;
    prev_pe = s_pix_en;
    prev_snap = {s_x, s_y, s_hs, s_vs, s_vo, s_pat, f_x, f_y};
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      snap = {s_x, s_y, s_hs, s_vs, s_vo, s_pat, f_x, f_y};
      if (s_pix_en && prev_pe) dbl++;
      if (!s_pix_en) begin
        if (snap !== prev_snap) unstable++;
        if (s_fs || s_ls || f_fs || f_ls) unstable++;
        gap++;
      end else begin
        if (gap != 3) badgap++;
        gap = 0;
      end
      prev_pe = s_pix_en;
      prev_snap = snap;
    end
    tests++;
    if (dbl !== 0) begin fails++; $display("[TB] FAIL pix_en_double: got %0d back-to-back, want 0", dbl); end
    tests++;
    if (badgap !== 0) begin fails++; $display("[TB] FAIL pix_en_gap: got %0d bad gaps, want 0", badgap); end
    tests++;
    if (unstable !== 0) begin fails++; $display("[TB] FAIL hold_between_ticks: got %0d changes, want 0", unstable); end
  endtask

  // Asynchronous reset mid-clock at (30,10) on the reduced instance
  task automatic test_mid_reset();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 3000 && !(s_x == 10'd30 && s_y == 10'd10); i++) begin
      next_tick(ok);
      if (!ok) return;
    end
    tests++;
    if ({s_x, s_y} !== {10'd30, 10'd10}) begin fails++; $display("[TB] FAIL midrst_reach: got (%0d,%0d), want (30,10)", s_x, s_y); return; end
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if ({s_x, s_y, f_x, f_y} !== {10'd79, 10'd31, 10'd799, 10'd524}) begin
      fails++; $display("[TB] FAIL midrst_xy: got (%0d,%0d) full (%0d,%0d), want (79,31) (799,524)", s_x, s_y, f_x, f_y);
    end
    tests++;
    if ({s_pix_en, s_hs, s_vs, s_vo, s_fs, s_ls, s_pat} !== {6'b011000, 12'h000}) begin
      fails++; $display("[TB] FAIL midrst_flags: pe/hs/vs/vo/fs/ls got %b pat %h, want 011000 pat 000", {s_pix_en, s_hs, s_vs, s_vo, s_fs, s_ls}, s_pat);
    end
    repeat (3) @(posedge clk);
    release_and_check_first_tick("midrst");
  endtask

  initial begin
    $display("[TB] vga_timing_gen directed bench");
    test_reset();
    test_line();
    test_frame();
    test_pix_en();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
